// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader: Wishbone initiator that streams coefficient
// words into the two-stage biquad coefficient target.
module biquad_coeff_loader #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3,
  parameter string       WBCLKTYPE = "NONE"
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [7:0]  base_adr_i,
  input  logic [6:0]  count_i,
  input  logic        update_en_i,
  input  logic [31:0] coef_dat_i,
  input  logic        coef_valid_i,
  output logic        coef_ready_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic        notch_update_o
);

  localparam logic [15:0] LP_TMO = 16'(TIMEOUT);
  localparam logic [3:0]  LP_RTY = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_GAP, S_UPDATE, S_DONE
  } state_t;

  state_t      r_state, w_state_n;
  logic [7:0]  r_adr, w_adr_n;
  logic [6:0]  r_cnt, w_cnt_n;
  logic        r_upd, w_upd_n;
  logic [31:0] r_dat, w_dat_n;
  logic [3:0]  r_rty, w_rty_n;
  logic [15:0] r_tmo, w_tmo_n;
  logic        r_error, w_error_n;
  logic [1:0]  r_code, w_code_n;
  logic        r_ready, r_cyc, r_busy;
  logic        r_done, r_notch;
  logic        w_unused;

  // Address low bits are word-aligned away; clock tag is informational.
  assign w_unused = ^{base_adr_i[1:0], (WBCLKTYPE != "")};

  // Next-state and datapath updates; err beats rty beats ack.
  always_comb begin
    w_state_n = r_state;
    w_adr_n   = r_adr;
    w_cnt_n   = r_cnt;
    w_upd_n   = r_upd;
    w_dat_n   = r_dat;
    w_rty_n   = r_rty;
    w_tmo_n   = r_tmo;
    w_error_n = r_error;
    w_code_n  = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_adr_n   = {base_adr_i[7:2], 2'b00};
          w_cnt_n   = count_i;
          w_upd_n   = update_en_i;
          w_error_n = 1'b0;
          w_code_n  = 2'd0;
          w_state_n = (count_i == 7'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (coef_valid_i && r_ready) begin
          w_dat_n   = coef_dat_i;
          w_rty_n   = 4'd0;
          w_tmo_n   = 16'd0;
          w_state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wb_err_i) begin
          w_error_n = 1'b1;
          w_code_n  = 2'd1;
          w_state_n = S_DONE;
        end else if (wb_rty_i) begin
          if (r_rty < LP_RTY) begin
            w_rty_n   = r_rty + 4'd1;
            w_state_n = S_GAP;
          end else begin
            w_error_n = 1'b1;
            w_code_n  = 2'd2;
            w_state_n = S_DONE;
          end
        end else if (wb_ack_i) begin
          w_adr_n = r_adr + 8'd4;
          w_cnt_n = r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            w_state_n = r_upd ? S_UPDATE : S_DONE;
          end else begin
            w_state_n = S_FETCH;
          end
        end else if ((r_tmo + 16'd1) == LP_TMO) begin
          w_error_n = 1'b1;
          w_code_n  = 2'd3;
          w_state_n = S_DONE;
        end else begin
          w_tmo_n = r_tmo + 16'd1;
        end
      end
      S_GAP: begin
        w_tmo_n   = 16'd0;
        w_state_n = S_WRITE;
      end
      S_UPDATE: w_state_n = S_DONE;
      S_DONE:   w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_cnt   <= '0;
      r_upd   <= 1'b0;
      r_dat   <= '0;
      r_rty   <= '0;
      r_tmo   <= '0;
      r_error <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_adr   <= w_adr_n;
      r_cnt   <= w_cnt_n;
      r_upd   <= w_upd_n;
      r_dat   <= w_dat_n;
      r_rty   <= w_rty_n;
      r_tmo   <= w_tmo_n;
      r_error <= w_error_n;
      r_code  <= w_code_n;
    end
  end

  // Output flags registered from the upcoming state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ready <= 1'b0;
      r_cyc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_notch <= 1'b0;
    end else begin
      r_ready <= (w_state_n == S_FETCH);
      r_cyc   <= (w_state_n == S_WRITE);
      r_busy  <= (w_state_n != S_IDLE);
      r_done  <= (w_state_n == S_DONE);
      r_notch <= (w_state_n == S_UPDATE);
    end
  end

  assign coef_ready_o   = r_ready;
  assign wb_cyc_o       = r_cyc;
  assign wb_stb_o       = r_cyc;
  assign wb_we_o        = r_cyc;
  assign wb_sel_o       = {4{r_cyc}};
  assign wb_adr_o       = r_adr;
  assign wb_dat_o       = r_dat;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign error_o        = r_error;
  assign err_code_o     = r_code;
  assign notch_update_o = r_notch;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader: directed bench with a scripted
// Wishbone target and a coefficient stream source.
module tb_biquad_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  base_adr_i = '0;
  logic [6:0]  count_i = '0;
  logic        update_en_i = 1'b0;
  logic [31:0] coef_dat_i = '0;
  logic        coef_valid_i = 1'b0;
  logic        coef_ready_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;
  logic        busy_o, done_o, error_o;
  logic [1:0]  err_code_o;
  logic        notch_update_o;

  always #5 clk = ~clk;

  biquad_coeff_loader #(
    .TIMEOUT(16), .MAX_RETRY(3), .WBCLKTYPE("NONE")
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .start_i(start_i), .base_adr_i(base_adr_i),
    .count_i(count_i), .update_en_i(update_en_i),
    .coef_dat_i(coef_dat_i), .coef_valid_i(coef_valid_i),
    .coef_ready_o(coef_ready_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_code_o(err_code_o),
    .notch_update_o(notch_update_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] src_mem [16];
  int src_len = 0;
  int src_idx = 0;
  int hold_idx = -1;
  int hold_left = 0;
  bit src_hs = 1'b0;
  bit silent = 1'b0;
  int resp_q [$];
  logic [7:0]  stb_adr [$];
  logic [31:0] stb_dat [$];
  int stb_t [$];
  int tick = 0;
  int notch_n = 0;
  int notch_t = -1;
  int done_n = 0;
  int done_t = -1;
  int strobe_bad = 0;

  // Stream source, scripted target responder and bus monitor.
  always @(negedge clk) begin
    int r;
    if (src_hs) src_idx++;
    coef_valid_i = (src_idx < src_len);
    if (coef_valid_i && src_idx == hold_idx && hold_left > 0) begin
      coef_valid_i = 1'b0;
      hold_left--;
    end
    coef_dat_i = src_mem[src_idx[3:0]];
    src_hs = coef_valid_i && coef_ready_o;
    wb_ack_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_we_o !== wb_stb_o || wb_cyc_o !== wb_stb_o ||
        wb_sel_o !== {4{wb_stb_o}})
      strobe_bad++;
    if (wb_stb_o) begin
      stb_adr.push_back(wb_adr_o);
      stb_dat.push_back(wb_dat_o);
      stb_t.push_back(tick);
      if (!silent) begin
        r = (resp_q.size() > 0) ? resp_q.pop_front() : 1;
        case (r)
          2: wb_rty_i = 1'b1;
          3: wb_err_i = 1'b1;
          4: begin
            wb_err_i = 1'b1; wb_rty_i = 1'b1; wb_ack_i = 1'b1;
          end
          5: begin wb_rty_i = 1'b1; wb_ack_i = 1'b1; end
          default: wb_ack_i = 1'b1;
        endcase
      end
    end
    if (notch_update_o) begin notch_n++; notch_t = tick; end
    if (done_o) begin done_n++; done_t = tick; end
    tick++;
  end

  task automatic clr(input int len, input logic [31:0] seed);
    src_idx = 0; src_hs = 1'b0; src_len = len;
    hold_idx = -1; hold_left = 0; silent = 1'b0;
    resp_q.delete(); stb_adr.delete();
    stb_dat.delete(); stb_t.delete();
    notch_n = 0; notch_t = -1; done_n = 0; done_t = -1;
    strobe_bad = 0;
    for (int i = 0; i < 16; i++) src_mem[i] = seed + 32'(i * 3);
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] c,
                          input logic u, output int t0);
    start_i = 1'b1; base_adr_i = b; count_i = c; update_en_i = u;
    @(posedge clk); #1;
    start_i = 1'b0; t0 = tick;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (done_n > 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
         coef_ready_o, busy_o, done_o, error_o, err_code_o,
         notch_update_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got adr=%h dat=%h busy=%b", wb_adr_o,
               wb_dat_o, busy_o);
    end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_o, wb_cyc_o, coef_ready_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle got %b exp 000",
               {busy_o, wb_cyc_o, coef_ready_o});
    end
  endtask

  task automatic test_basic;
    int t0; bit ok; logic [7:0] a; logic [31:0] d;
    @(posedge clk); #1;
    clr(4, 32'hC0DE_0100);
    do_start(8'h00, 7'd4, 1'b1, t0);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL basic_busy got %b exp 1", busy_o);
    end
    wait_done(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_done got 0 exp 1"); end
    n_cmp++;
    if (stb_t.size() != 4) begin
      n_bad++; $display("FAIL basic_nstb got %0d exp 4", stb_t.size());
    end
    for (int i = 0; i < 4; i++) begin
      a = (i < stb_adr.size()) ? stb_adr[i] : 8'hxx;
      d = (i < stb_dat.size()) ? stb_dat[i] : 'x;
      n_cmp++;
      if (a !== 8'(i * 4)) begin
        n_bad++; $display("FAIL basic_adr%0d got %h exp %h", i, a, i * 4);
      end
      n_cmp++;
      if (d !== 32'hC0DE_0100 + 32'(i * 3)) begin
        n_bad++; $display("FAIL basic_dat%0d got %h", i, d);
      end
    end
    n_cmp++;
    if (stb_t.size() < 4 || stb_t[0] != t0 + 1 || stb_t[3] != t0 + 7) begin
      n_bad++; $display("FAIL basic_timing got first %0d exp %0d",
                        stb_t.size() > 0 ? stb_t[0] : -1, t0 + 1);
    end
    n_cmp++;
    if (notch_n != 1 || done_n != 1 || done_t != notch_t + 1) begin
      n_bad++; $display("FAIL basic_pulses got notch %0d@%0d done %0d@%0d",
                        notch_n, notch_t, done_n, done_t);
    end
    n_cmp++;
    if ({error_o, err_code_o, busy_o} !== 4'b0000 || src_idx != 4) begin
      n_bad++; $display("FAIL basic_end got err %b code %0d busy %b idx %0d",
                        error_o, err_code_o, busy_o, src_idx);
    end
    n_cmp++;
    if (strobe_bad != 0) begin
      n_bad++; $display("FAIL strobe_we_sel got %0d exp 0", strobe_bad);
    end
  endtask

  task automatic test_wrap;
    int t0; bit ok;
    @(posedge clk); #1;
    clr(3, 32'h0000_7000);
    do_start(8'h7C, 7'd3, 1'b0, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_adr.size() != 3 ||
        {stb_adr[0], stb_adr[1], stb_adr[2]} !== 24'h7C8084) begin
      n_bad++; $display("FAIL wrap_ab got n=%0d ok=%b exp 7C 80 84",
                        stb_adr.size(), ok);
    end
    n_cmp++;
    if (notch_n != 0 || done_n != 1) begin
      n_bad++; $display("FAIL wrap_noupd got notch %0d done %0d exp 0 1",
                        notch_n, done_n);
    end
    @(posedge clk); #1;
    clr(2, 32'h0000_F000);
    do_start(8'hFD, 7'd2, 1'b0, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_adr.size() != 2 ||
        {stb_adr[0], stb_adr[1]} !== 16'hFC00) begin
      n_bad++; $display("FAIL wrap_top got n=%0d ok=%b exp FC 00",
                        stb_adr.size(), ok);
    end
  endtask

  task automatic test_retry;
    int t0; bit ok;
    @(posedge clk); #1;
    clr(1, 32'h0000_AAA0);
    resp_q = '{2, 2, 1};
    do_start(8'h20, 7'd1, 1'b1, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_t.size() != 3 || stb_t[1] != stb_t[0] + 2 ||
        stb_t[2] != stb_t[0] + 4) begin
      n_bad++; $display("FAIL rty2_attempts got %0d exp 3 spaced 2",
                        stb_t.size());
    end
    n_cmp++;
    if (stb_adr.size() != 3 || stb_adr[2] !== 8'h20 ||
        stb_dat[2] !== 32'h0000_AAA0 || stb_adr[1] !== 8'h20) begin
      n_bad++; $display("FAIL rty2_same_word got n=%0d", stb_adr.size());
    end
    n_cmp++;
    if (error_o !== 1'b0 || notch_n != 1) begin
      n_bad++; $display("FAIL rty2_ok got err %b notch %0d exp 0 1",
                        error_o, notch_n);
    end
    @(posedge clk); #1;
    clr(1, 32'h0000_BBB0);
    resp_q = '{2, 2, 2, 1};
    do_start(8'h24, 7'd1, 1'b0, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_t.size() != 4 || error_o !== 1'b0) begin
      n_bad++; $display("FAIL rty3_ok got n=%0d err %b exp 4 0",
                        stb_t.size(), error_o);
    end
    @(posedge clk); #1;
    clr(2, 32'h0000_CCC0);
    resp_q = '{2, 2, 2, 2};
    do_start(8'h28, 7'd2, 1'b1, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_t.size() != 4) begin
      n_bad++; $display("FAIL rty4_attempts got %0d exp 4", stb_t.size());
    end
    n_cmp++;
    if (error_o !== 1'b1 || err_code_o !== 2'd2) begin
      n_bad++; $display("FAIL rty4_code got err %b code %0d exp 1 2",
                        error_o, err_code_o);
    end
    n_cmp++;
    if (notch_n != 0 || done_n != 1 || src_idx != 1) begin
      n_bad++; $display("FAIL rty4_end got notch %0d done %0d idx %0d",
                        notch_n, done_n, src_idx);
    end
  endtask

  task automatic test_fail;
    int t0; bit ok;
    @(posedge clk); #1;
    clr(1, 32'h0000_D000);
    silent = 1'b1;
    do_start(8'h30, 7'd1, 1'b1, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_t.size() != 16 || stb_t[15] != stb_t[0] + 15) begin
      n_bad++; $display("FAIL tmo_len got %0d exp 16", stb_t.size());
    end
    n_cmp++;
    if (error_o !== 1'b1 || err_code_o !== 2'd3 || notch_n != 0) begin
      n_bad++; $display("FAIL tmo_code got err %b code %0d exp 1 3",
                        error_o, err_code_o);
    end
    @(posedge clk); #1;
    clr(5, 32'h0000_E000);
    resp_q = '{1, 3};
    do_start(8'h30, 7'd5, 1'b1, t0);
    n_cmp++;
    if (error_o !== 1'b0 || err_code_o !== 2'd0) begin
      n_bad++; $display("FAIL err_clear got err %b code %0d exp 0 0",
                        error_o, err_code_o);
    end
    wait_done(100, ok);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (!ok || stb_adr.size() != 2 ||
        {stb_adr[0], stb_adr[1]} !== 16'h3034) begin
      n_bad++; $display("FAIL err_writes got %0d exp 2", stb_adr.size());
    end
    n_cmp++;
    if (error_o !== 1'b1 || err_code_o !== 2'd1 || notch_n != 0) begin
      n_bad++; $display("FAIL err_code got err %b code %0d exp 1 1",
                        error_o, err_code_o);
    end
    n_cmp++;
    if (src_idx != 2 || coef_ready_o !== 1'b0) begin
      n_bad++; $display("FAIL err_unconsumed got idx %0d rdy %b exp 2 0",
                        src_idx, coef_ready_o);
    end
    @(posedge clk); #1;
    clr(1, 32'h0000_E100);
    resp_q = '{4};
    do_start(8'h40, 7'd1, 1'b0, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || err_code_o !== 2'd1 || stb_t.size() != 1) begin
      n_bad++; $display("FAIL prio_err got code %0d n=%0d exp 1 1",
                        err_code_o, stb_t.size());
    end
    @(posedge clk); #1;
    clr(1, 32'h0000_E200);
    resp_q = '{5, 1};
    do_start(8'h44, 7'd1, 1'b0, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || error_o !== 1'b0 || stb_t.size() != 2) begin
      n_bad++; $display("FAIL prio_rty got err %b n=%0d exp 0 2",
                        error_o, stb_t.size());
    end
  endtask

  task automatic test_stall;
    int t0; bit ok;
    @(posedge clk); #1;
    clr(3, 32'h0000_5000);
    hold_idx = 1; hold_left = 10;
    do_start(8'h50, 7'd3, 1'b1, t0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({wb_cyc_o, busy_o, coef_ready_o} !== 3'b011) begin
      n_bad++; $display("FAIL stall_idle got %b exp 011",
                        {wb_cyc_o, busy_o, coef_ready_o});
    end
    start_i = 1'b1; base_adr_i = 8'h90; count_i = 7'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({wb_cyc_o, busy_o} !== 2'b01) begin
      n_bad++; $display("FAIL stall_hold got %b exp 01",
                        {wb_cyc_o, busy_o});
    end
    wait_done(100, ok);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (!ok || stb_adr.size() != 3 ||
        {stb_adr[0], stb_adr[1], stb_adr[2]} !== 24'h505458) begin
      n_bad++; $display("FAIL stall_adrs got n=%0d exp 50 54 58",
                        stb_adr.size());
    end
    n_cmp++;
    if (stb_t.size() != 3 || stb_t[1] != stb_t[0] + 11) begin
      n_bad++; $display("FAIL stall_gap got %0d exp 11",
                        stb_t.size() > 1 ? stb_t[1] - stb_t[0] : -1);
    end
    n_cmp++;
    if (busy_o !== 1'b0 || done_n != 1 || notch_n != 1) begin
      n_bad++; $display("FAIL busy_start got busy %b done %0d exp 0 1",
                        busy_o, done_n);
    end
    @(posedge clk); #1;
    clr(0, 32'h0);
    do_start(8'h60, 7'd0, 1'b1, t0);
    wait_done(20, ok);
    n_cmp++;
    if (!ok || done_t != t0 || stb_t.size() != 0 || notch_n != 0) begin
      n_bad++; $display("FAIL zero_count got done@%0d exp %0d n=%0d",
                        done_t, t0, stb_t.size());
    end
  endtask

  task automatic test_reset_midload;
    int t0; bit ok;
    @(posedge clk); #1;
    clr(2, 32'h0000_6000);
    silent = 1'b1;
    do_start(8'h68, 7'd2, 1'b1, t0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wb_stb_o) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_stb got 0 exp 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
         coef_ready_o, busy_o, done_o, error_o, err_code_o,
         notch_update_o} !== '0) begin
      n_bad++; $display("FAIL rst_async got cyc %b adr %h dat %h",
                        wb_cyc_o, wb_adr_o, wb_dat_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clr(1, 32'h0000_7100);
    do_start(8'h10, 7'd1, 1'b1, t0);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || stb_adr.size() != 1 || stb_adr[0] !== 8'h10 ||
        stb_dat[0] !== 32'h0000_7100 || notch_n != 1) begin
      n_bad++; $display("FAIL rst_restart got n=%0d ok=%b",
                        stb_adr.size(), ok);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_retry();
    test_fail();
    test_stall();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
